sipo_rx: RTL
============

Name: sipo_rx

Overview:
Serial-in, parallel-out deserializer; the receive end of the team's 4-bit MSB-first shift-register serial link.
- Collects WIDTH bits from a bit-strobed serial stream, framed by a start marker.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Double-buffered: the next word shifts in while the previous word waits for the consumer.

Parameters:
WIDTH, 4, data bits per word (legal range 2..32)
MSB_FIRST, 1, 1 = first received bit lands in par_out[WIDTH-1]; 0 = first bit lands in par_out[0]

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
ser_in  input  1  serial data bit, sampled only when ser_valid=1
ser_valid  input  1  bit strobe; one bit accepted per cycle with ser_valid=1
frame_start  input  1  qualified by ser_valid; marks the current bit as bit 0 of a word
par_out  output  WIDTH  received word, stable while par_valid=1
par_valid  output  1  par_out holds an unconsumed word
par_ready  input  1  consumer accepts word when par_valid&&par_ready
busy  output  1  1 while in SHIFT (word partially received)
overrun  output  1  sticky: a completed word was dropped
frame_err  output  1  one-cycle pulse: frame_start arrived mid-word
overrun_clr  input  1  synchronous clear of overrun
par_perr  output  1  parity error flag for word on par_out (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bit counter=0, shift register=0.
  - par_out=0, par_valid=0, busy=0, overrun=0, frame_err=0, par_perr=0.
  - Reset mid-word discards the partial word and any held word.
- FSM states IDLE and SHIFT:
  - IDLE: ser_valid=1 with frame_start=1 captures ser_in as bit 0, sets cnt=1, and goes to SHIFT. ser_valid=1 with frame_start=0 is ignored (no error).
  - SHIFT: each ser_valid=1 captures ser_in into the next position and increments cnt. Cycles with ser_valid=0 hold all state; gaps of any length are allowed.
  - Word complete: the cycle that captures bit WIDTH-1 completes the word. Return to IDLE and set cnt=0.
  - Completion with frame_start=1 on that last bit: treated as resync (next bullet), not completion.
  - Resync: frame_start=1 with ser_valid=1 while in SHIFT. Pulse frame_err for one cycle, discard the partial word, capture the current bit as bit 0, set cnt=1, stay in SHIFT.
- Bit placement:
  - MSB_FIRST=1: received bit k goes to par_out[WIDTH-1-k].
  - MSB_FIRST=0: received bit k goes to par_out[k].
- Output handoff:
  - Latency: the word completed at edge N is on par_out with par_valid=1 from edge N (visible the cycle after the last bit is presented).
  - Completion with par_valid=0 loads par_out and sets par_valid=1.
  - Completion with par_valid=1 and par_ready=1 in the same cycle: the old word is consumed, the new word loads, and par_valid stays 1 (no bubble).
  - Completion with par_valid=1 and par_ready=0: the new word is dropped, par_out is unchanged, and overrun is set.
  - par_valid&&par_ready with no completion clears par_valid; par_out holds its last value.
- overrun:
  - Cleared only by reset or overrun_clr=1.
  - If overrun_clr and a new overrun event occur in the same cycle, overrun stays 1 (set wins).
- busy=1 exactly while state=SHIFT.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - Each word carries one extra even-parity bit, received after data bit WIDTH-1 with ser_valid=1.
  - Completion moves to the parity-bit capture cycle.
  - par_perr loads with the word: 1 if XOR(data bits, parity bit)=1.
  - par_perr follows par_out under the same handoff and drop rules.
  - frame_start on the parity bit is a resync.
- Not defined: par_perr is tied to 0, and words are exactly WIDTH bits.

Test Plan:
- Reset then frame_start+bits 1,0,1,1 on consecutive ser_valid cycles (WIDTH=4, MSB_FIRST=1) -> par_out=4'b1011 and par_valid=1 the cycle after the 4th bit; busy=1 during bits 2-4.
- Same word 4'b0110 with 3 idle cycles between each bit -> par_out=4'b0110; busy held through the gaps; no frame_err.
- Hold par_ready=0 and send words 4'hA then 4'h5 -> par_out stays 4'hA, overrun=1; overrun_clr -> overrun=0; par_ready=1 -> par_valid drops.
- Word 4'h3 held, then 4'hC completes in the same cycle as par_ready=1 -> par_valid stays 1 and par_out=4'hC with no gap.
- Send 2 bits, then frame_start with bits 1,1,1,1 -> frame_err pulses once and par_out=4'hF; rst_n low after 2 bits of a further word -> all outputs 0 and state IDLE.
- With SIPO_PARITY_EN: send 4'b1011 with parity bit 1 -> par_perr=0; repeat with parity bit 0 -> par_perr=1.

Source files
------------

// File: rtl/sipo_rx.sv
// sipo_rx: bit-strobed serial-in, parallel-out receiver with a double-buffered word output.
// Define SIPO_PARITY_EN to append one even-parity bit per word and flag it on par_perr.
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             overrun_clr,
  output logic             par_perr
);

`ifdef SIPO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = WIDTH + PB;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             acc;

  logic             start;
  logic             resync;
  logic             step;
  logic             done;
  logic             restart;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] word;
  logic             acc_nx;

  assign start   = ser_valid && frame_start && (state == IDLE);
  assign resync  = ser_valid && frame_start && (state == SHIFT);
  assign step    = ser_valid && !frame_start && (state == SHIFT);
  assign done    = step && (cnt == CW'(NB - 1));
  assign restart = frame_start || (state == IDLE);
  assign idx     = restart ? '0 : cnt;

  // Parity bit index (== WIDTH) matches no data position, so word is untouched
  always_comb begin
    word   = restart ? '0 : sreg;
    acc_nx = (restart ? 1'b0 : acc) ^ ser_in;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(idx) == (MSB_FIRST ? WIDTH - 1 - i : i)) begin
        word[i] = ser_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      acc       <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= resync;
      if (start || resync) begin
        state <= SHIFT;
        busy  <= 1'b1;
        cnt   <= CW'(1);
        sreg  <= word;
        acc   <= acc_nx;
      end else if (done) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
        sreg  <= '0;
        acc   <= 1'b0;
      end else if (step) begin
        cnt  <= cnt + CW'(1);
        sreg <= word;
        acc  <= acc_nx;
      end
    end
  end

  // Output buffer; a drop sets overrun after the clear so set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_out   <= '0;
      par_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (overrun_clr) overrun <= 1'b0;
      if (done) begin
        if (!par_valid || par_ready) begin
          par_out   <= word;
          par_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (par_valid && par_ready) begin
        par_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_perr <= 1'b0;
    end else if (done && (!par_valid || par_ready)) begin
      par_perr <= acc_nx;
    end
  end
`else
  assign par_perr = 1'b0;
`endif

endmodule
